// File: rtl/stack_arbiter.sv
// Arbitrates NUM_REQ push/pop requesters onto one LIFO stack, one transaction at a time.
// Define STACK_ARB_STRICT_PRIO_EN for fixed lowest-index priority; the default build is round-robin.
module stack_arbiter #(
  parameter int  DATA_WIDTH = 8,
  parameter int  NUM_REQ    = 4,
  localparam int IDX_W      = $clog2(NUM_REQ)
) (
  input  logic                          CLK,
  input  logic                          RST_N,
  input  logic [NUM_REQ-1:0]            REQ_VALID,
  input  logic [NUM_REQ-1:0]            REQ_OP,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] REQ_DATA,
  output logic [NUM_REQ-1:0]            REQ_READY,
  output logic [NUM_REQ-1:0]            RSP_VALID,
  output logic [DATA_WIDTH-1:0]         RSP_DATA,
  output logic                          RSP_ERR,
  output logic                          BUSY,
  output logic                          STK_PUSH,
  output logic                          STK_POP,
  output logic [DATA_WIDTH-1:0]         STK_DATA_IN,
  input  logic [DATA_WIDTH-1:0]         STK_DATA_OUT,
  input  logic                          STK_FULL,
  input  logic                          STK_EMPTY,
  output logic [1:0]                    DBG_STATE
);

  // Handshake: request i transfers in the cycle REQ_VALID[i] && REQ_READY[i]. REQ_READY is only
  // offered in IDLE, only to the winner; a requester may drop REQ_VALID any time before that.
  typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, RESP = 2'd2} state_t;

  state_t                  state_q, state_d;
`ifndef STACK_ARB_STRICT_PRIO_EN
  logic [IDX_W-1:0]        last_q;
`endif
  logic [IDX_W-1:0]        idx_q, win;
  logic                    found, grant, win_op;
  logic [DATA_WIDTH-1:0]   win_data;
  logic                    err_q, push_q, pop_q, rsp_err_q;
  logic [DATA_WIDTH-1:0]   din_q, rsp_data_q;
  logic [NUM_REQ-1:0]      rsp_valid_q, ready;
  int                      cand;

  always_comb begin
    found = 1'b0;
    win   = '0;
    cand  = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
`ifdef STACK_ARB_STRICT_PRIO_EN
      cand = k;
`else
      cand = int'(last_q) + 1 + k;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
`endif
      if (!found && REQ_VALID[cand[IDX_W-1:0]]) begin
        found = 1'b1;
        win   = cand[IDX_W-1:0];
      end
    end
  end

  always_comb begin
    win_op   = REQ_OP[win];
    win_data = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (win == IDX_W'(k)) win_data = REQ_DATA[k*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  assign grant = (state_q == IDLE) && found && RST_N;

  always_comb begin
    state_d = state_q;
    ready   = '0;
    case (state_q)
      IDLE: begin
        if (grant) begin
          ready[win] = 1'b1;
          state_d    = ISSUE;
        end
      end
      ISSUE:   state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FULL/EMPTY are sampled at the grant edge: nothing else drives the stack, so they are the
  // values ISSUE would see, and the strobes can then be registered into the ISSUE cycle.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q     <= IDLE;
`ifndef STACK_ARB_STRICT_PRIO_EN
      last_q      <= IDX_W'(NUM_REQ - 1);
`endif
      idx_q       <= '0;
      err_q       <= 1'b0;
      push_q      <= 1'b0;
      pop_q       <= 1'b0;
      din_q       <= '0;
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      push_q      <= 1'b0;
      pop_q       <= 1'b0;
      rsp_valid_q <= '0;
      rsp_err_q   <= 1'b0;
      if (grant) begin
        idx_q  <= win;
        din_q  <= win_data;
`ifndef STACK_ARB_STRICT_PRIO_EN
        last_q <= win;
`endif
        push_q <= win_op && !STK_FULL;
        pop_q  <= !win_op && !STK_EMPTY;
        err_q  <= win_op ? STK_FULL : STK_EMPTY;
      end
      if (state_q == RESP) begin
        rsp_valid_q <= {{(NUM_REQ-1){1'b0}}, 1'b1} << idx_q;
        rsp_data_q  <= err_q ? '0 : STK_DATA_OUT;
        rsp_err_q   <= err_q;
      end
    end
  end

  // Gating with RST_N keeps a reset that lands in ISSUE from writing the stack at that edge.
  assign STK_PUSH    = push_q & RST_N;
  assign STK_POP     = pop_q & RST_N;
  assign STK_DATA_IN = din_q;
  assign REQ_READY   = ready;
  assign RSP_VALID   = rsp_valid_q;
  assign RSP_DATA    = rsp_data_q;
  assign RSP_ERR     = rsp_err_q;
  assign BUSY        = (state_q != IDLE);
  assign DBG_STATE   = state_q;

endmodule

// File: tb/tb_stack_arbiter.sv
// Self-checking bench for stack_arbiter: a 4-deep behavioural stack plus an arbitration/stack
// reference model predicting grants, strobes and responses.
module tb_stack_arbiter;
  localparam int DW    = 8;
  localparam int N     = 4;
  localparam int DEPTH = 4;

  logic            CLK = 1'b0;
  logic            RST_N = 1'b0;
  logic [N-1:0]    REQ_VALID = '0;
  logic [N-1:0]    REQ_OP = '0;
  logic [N*DW-1:0] REQ_DATA = '0;
  logic [N-1:0]    REQ_READY, RSP_VALID;
  logic [DW-1:0]   RSP_DATA, STK_DATA_IN, STK_DATA_OUT;
  logic            RSP_ERR, BUSY, STK_PUSH, STK_POP, STK_FULL, STK_EMPTY;
  logic [1:0]      DBG_STATE;

  stack_arbiter #(.DATA_WIDTH(DW), .NUM_REQ(N)) dut (
    .CLK(CLK), .RST_N(RST_N), .REQ_VALID(REQ_VALID), .REQ_OP(REQ_OP), .REQ_DATA(REQ_DATA),
    .REQ_READY(REQ_READY), .RSP_VALID(RSP_VALID), .RSP_DATA(RSP_DATA), .RSP_ERR(RSP_ERR),
    .BUSY(BUSY), .STK_PUSH(STK_PUSH), .STK_POP(STK_POP), .STK_DATA_IN(STK_DATA_IN),
    .STK_DATA_OUT(STK_DATA_OUT), .STK_FULL(STK_FULL), .STK_EMPTY(STK_EMPTY), .DBG_STATE(DBG_STATE)
  );

  always #5 CLK = ~CLK;

  // Behavioural stack the arbiter drives; read data is registered, as in the real stack.
  logic [DW-1:0] stk_q[$];
  int            stk_cnt = 0;
  logic [DW-1:0] stk_dout = '0;
  assign STK_DATA_OUT = stk_dout;
  assign STK_FULL     = (stk_cnt == DEPTH);
  assign STK_EMPTY    = (stk_cnt == 0);

  always @(posedge CLK) begin
    if (STK_PUSH) begin
      if (stk_q.size() < DEPTH) stk_q.push_back(STK_DATA_IN);
      stk_dout <= STK_DATA_IN;
    end else if (STK_POP && stk_q.size() > 0) begin
      stk_dout <= stk_q.pop_back();
    end
    stk_cnt <= stk_q.size();
  end

  // Reference model state
  int            n_cmp = 0;
  int            n_bad = 0;
  int            ref_last = N - 1;
  logic [DW-1:0] ref_stk[$];
  logic [DW-1:0] last_rsp;

  function automatic int ref_pick(input logic [N-1:0] v);
`ifdef STACK_ARB_STRICT_PRIO_EN
    for (int i = 0; i < N; i++) if (v[i]) return i;
`else
    for (int k = 1; k <= N; k++) if (v[(ref_last + k) % N]) return (ref_last + k) % N;
`endif
    return -1;
  endfunction

  // Entered in an IDLE cycle with inputs settled; returns at the response cycle (T+3).
  task automatic run_txn(output int win);
    logic [N-1:0]  exp_oh;
    logic          op, exp_err, exp_push, exp_pop;
    logic [DW-1:0] d, exp_data;
    win    = ref_pick(REQ_VALID);
    exp_oh = N'(1) << win;
    n_cmp++;
    if (REQ_READY !== exp_oh) begin
      n_bad++; $display("FAIL grant: REQ_READY=%b expected %b", REQ_READY, exp_oh);
    end
    n_cmp++;
    if (BUSY !== 1'b0) begin
      n_bad++; $display("FAIL busy_idle: BUSY=%b expected 0", BUSY);
    end
    op = REQ_OP[win];
    d  = REQ_DATA[win*DW +: DW];
    if (op) begin
      exp_err  = (ref_stk.size() == DEPTH);
      exp_push = !exp_err;
      exp_pop  = 1'b0;
      exp_data = exp_err ? '0 : d;
      if (!exp_err) ref_stk.push_back(d);
    end else begin
      exp_err  = (ref_stk.size() == 0);
      exp_pop  = !exp_err;
      exp_push = 1'b0;
      exp_data = exp_err ? '0 : ref_stk[ref_stk.size()-1];
      if (!exp_err) void'(ref_stk.pop_back());
    end
`ifndef STACK_ARB_STRICT_PRIO_EN
    ref_last = win;
`endif
    @(negedge CLK);
    REQ_VALID[win] = 1'b0;
    n_cmp++;
    if ({STK_PUSH, STK_POP, BUSY, REQ_READY} !== {exp_push, exp_pop, 1'b1, N'(0)}) begin
      n_bad++; $display("FAIL issue: push/pop/busy/ready=%b%b%b/%b expected %b%b1/0000",
                        STK_PUSH, STK_POP, BUSY, REQ_READY, exp_push, exp_pop);
    end
    if (exp_push) begin
      n_cmp++;
      if (STK_DATA_IN !== d) begin
        n_bad++; $display("FAIL stk_data_in: %h expected %h", STK_DATA_IN, d);
      end
    end
    @(negedge CLK);
    n_cmp++;
    if ({STK_PUSH, STK_POP, BUSY, RSP_VALID} !== {2'b00, 1'b1, N'(0)}) begin
      n_bad++; $display("FAIL resp_state: push/pop/busy/rsp_valid=%b%b%b/%b expected 001/0000",
                        STK_PUSH, STK_POP, BUSY, RSP_VALID);
    end
    @(negedge CLK);
    n_cmp++;
    if ({RSP_VALID, RSP_ERR, RSP_DATA} !== {exp_oh, exp_err, exp_data}) begin
      n_bad++; $display("FAIL response: valid=%b err=%b data=%h expected valid=%b err=%b data=%h",
                        RSP_VALID, RSP_ERR, RSP_DATA, exp_oh, exp_err, exp_data);
    end
    last_rsp = exp_data;
  endtask

  task automatic test_reset();
    int w;
    RST_N     = 1'b0;
    REQ_VALID = '1;
    REQ_OP    = '0;
    REQ_DATA  = {$urandom, $urandom};
    repeat (2) begin
      @(negedge CLK); #1;
      n_cmp++;
      if ({REQ_READY, RSP_VALID, RSP_DATA, RSP_ERR, BUSY, STK_PUSH, STK_POP, STK_DATA_IN} !== '0) begin
        n_bad++; $display("FAIL reset_outputs: ready=%b rsp_valid=%b data=%h err=%b busy=%b push=%b pop=%b din=%h expected all 0",
                          REQ_READY, RSP_VALID, RSP_DATA, RSP_ERR, BUSY, STK_PUSH, STK_POP, STK_DATA_IN);
      end
    end
    RST_N = 1'b1;
    ref_last = N - 1;
    #1;
    run_txn(w);
    REQ_VALID = '0;
    @(negedge CLK);
    n_cmp++;
    if ({RSP_VALID, RSP_ERR, RSP_DATA} !== {N'(0), 1'b0, last_rsp}) begin
      n_bad++; $display("FAIL rsp_one_cycle: valid=%b err=%b data=%h expected 0000 0 %h",
                        RSP_VALID, RSP_ERR, RSP_DATA, last_rsp);
    end
  endtask

  task automatic test_push();
    int w;
    REQ_VALID = 4'b0010;
    REQ_OP    = 4'b0010;
    REQ_DATA[1*DW +: DW] = 8'hA5;
    #1;
    run_txn(w);
    REQ_VALID = '0;
  endtask

  task automatic test_pop_empty();
    int w;
    while (ref_stk.size() > 0) begin
      REQ_VALID = 4'b0001; REQ_OP = '0; #1;
      run_txn(w);
    end
    REQ_VALID = 4'b0001; REQ_OP = '0; #1;
    run_txn(w);
    REQ_VALID = '0;
  endtask

  task automatic test_push_full();
    int w;
    while (ref_stk.size() < DEPTH) begin
      REQ_VALID = 4'b0100; REQ_OP = 4'b0100;
      REQ_DATA[2*DW +: DW] = DW'($urandom); #1;
      run_txn(w);
    end
    REQ_VALID = 4'b0100; REQ_OP = 4'b0100;
    REQ_DATA[2*DW +: DW] = 8'h3C; #1;
    run_txn(w);
    REQ_VALID = '0;
  endtask

  task automatic test_contention();
    int w;
    int exp_seq[5];
`ifdef STACK_ARB_STRICT_PRIO_EN
    exp_seq = '{0, 0, 0, 0, 0};
`else
    exp_seq = '{0, 1, 2, 3, 0};
`endif
    RST_N = 1'b0; REQ_VALID = '0;
    @(negedge CLK);
    RST_N = 1'b1; ref_last = N - 1;
    REQ_VALID = '1; REQ_OP = N'($urandom); REQ_DATA = {$urandom, $urandom};
    #1;
    for (int i = 0; i < 5; i++) begin
      n_cmp++;
      if (REQ_READY !== (N'(1) << exp_seq[i])) begin
        n_bad++; $display("FAIL contention_order[%0d]: REQ_READY=%b expected %b",
                          i, REQ_READY, N'(1) << exp_seq[i]);
      end
      run_txn(w);
      REQ_VALID[w] = 1'b1;
      REQ_OP[w]    = 1'($urandom);
      REQ_DATA[w*DW +: DW] = DW'($urandom);
      #1;
    end
    REQ_VALID = '0;
  endtask

  task automatic test_abort();
    int w;
    if (ref_stk.size() == DEPTH) begin
      REQ_VALID = 4'b0001; REQ_OP = '0; #1;
      run_txn(w);
    end
    REQ_VALID = 4'b0010; REQ_OP = 4'b0010; REQ_DATA[1*DW +: DW] = 8'h77; #1;
    n_cmp++;
    if (REQ_READY !== 4'b0010) begin
      n_bad++; $display("FAIL abort_grant: REQ_READY=%b expected 0010", REQ_READY);
    end
    @(negedge CLK);
    REQ_VALID = '0;
    n_cmp++;
    if (STK_PUSH !== 1'b1) begin
      n_bad++; $display("FAIL abort_pre_push: STK_PUSH=%b expected 1", STK_PUSH);
    end
    RST_N = 1'b0; #1;
    n_cmp++;
    if (STK_PUSH !== 1'b0) begin
      n_bad++; $display("FAIL abort_push: STK_PUSH=%b expected 0", STK_PUSH);
    end
    @(negedge CLK);
    n_cmp++;
    if ({BUSY, RSP_VALID, STK_PUSH, STK_POP} !== {1'b0, N'(0), 2'b00}) begin
      n_bad++; $display("FAIL abort_state: busy=%b rsp_valid=%b push=%b pop=%b expected 0 0000 0 0",
                        BUSY, RSP_VALID, STK_PUSH, STK_POP);
    end
    @(negedge CLK);
    n_cmp++;
    if (RSP_VALID !== '0) begin
      n_bad++; $display("FAIL abort_rsp: RSP_VALID=%b expected 0000", RSP_VALID);
    end
    RST_N = 1'b1; ref_last = N - 1;
    n_cmp++;
    if (stk_q.size() !== ref_stk.size()) begin
      n_bad++; $display("FAIL abort_stack_depth: %0d expected %0d", stk_q.size(), ref_stk.size());
    end
  endtask

  task automatic test_random();
    int w;
    REQ_VALID = '0;
    for (int it = 0; it < 80; it++) begin
      for (int i = 0; i < N; i++) begin
        if (!REQ_VALID[i]) begin
          if ($urandom_range(0, 1) == 1) begin
            REQ_VALID[i] = 1'b1;
            REQ_OP[i]    = 1'($urandom_range(0, 1));
            REQ_DATA[i*DW +: DW] = DW'($urandom);
          end
        end else if ($urandom_range(0, 7) == 0) begin
          REQ_VALID[i] = 1'b0;
        end
      end
      #1;
      if (REQ_VALID == '0) begin
        n_cmp++;
        if ({REQ_READY, BUSY} !== '0) begin
          n_bad++; $display("FAIL idle: REQ_READY=%b BUSY=%b expected 0000 0", REQ_READY, BUSY);
        end
        @(negedge CLK);
      end else begin
        run_txn(w);
      end
    end
    REQ_VALID = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_push();
    test_pop_empty();
    test_push_full();
    test_contention();
    test_abort();
    test_random();
    @(negedge CLK);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
